// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// State encoding, stage-enable and strobe bundles.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IMISS = 2'd1,
    ST_DMISS = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  typedef struct packed {
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_flush;
  } strobe_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose rt feeds the
// instruction currently in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       load_use_o
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit     = (ex_rt_i == id_rs_i);
    rt_hit     = id_uses_rt_i & (ex_rt_i == id_rt_i);
    load_use_o = ex_mem_read_i
               & (ex_rt_i != REG_ZERO)
               & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Combinational enables, miss-tracking FSM, stall statistics.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MISS_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             miss_timeout,
  output logic [1:0]       state
);

  localparam int MC_W = $clog2(MISS_TIMEOUT) + 1;
  localparam logic [MC_W-1:0] MC_MAX = '1;
  localparam logic [MC_W-1:0] MC_LIM = MC_W'(MISS_TIMEOUT);
  localparam logic [CNT_W-1:0] SC_MAX = '1;

  state_e           state_q, state_d;
  logic [MC_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;
  logic             load_use;
  logic             d_miss;
  stage_en_t        en;
  strobe_t          stb;

  hazard_detect u_hazard (
    .ex_mem_read_i (ex_mem_read),
    .ex_rt_i       (ex_rt),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .load_use_o    (load_use)
  );

  // Once waiting on the D-cache, only the hit releases the freeze.
  always_comb begin
    if (state_q == ST_DMISS) d_miss = ~dcache_hit;
    else                     d_miss = dcache_req & ~dcache_hit;
  end

  always_comb begin
    en      = '1;
    stb     = '0;
    state_d = ST_RUN;
    priority case (1'b1)
      d_miss: begin
        en      = '0;
        state_d = ST_DMISS;
      end
      branch_taken: begin
        stb = '1;
      end
      !icache_hit: begin
        en.pc            = 1'b0;
        en.if_id         = 1'b0;
        stb.id_ex_bubble = 1'b1;
        state_d          = ST_IMISS;
      end
      load_use: begin
        en.pc            = 1'b0;
        en.if_id         = 1'b0;
        stb.id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      en  = '0;
      stb = '0;
    end
  end

  always_comb begin
    miss_cnt_d = '0;
    if (state_d != ST_RUN) begin
      if (miss_cnt_q == MC_MAX) miss_cnt_d = miss_cnt_q;
      else                      miss_cnt_d = miss_cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (miss_cnt_d >= MC_LIM);
    stall_d   = stall_q;
    if (!en.pc && stall_q != SC_MAX) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      miss_cnt_q <= '0;
      stall_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      miss_cnt_q <= miss_cnt_d;
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pc_en        = en.pc;
  assign if_id_en     = en.if_id;
  assign id_ex_en     = en.id_ex;
  assign ex_mem_en    = en.ex_mem;
  assign mem_wb_en    = en.mem_wb;
  assign if_id_flush  = stb.if_id_flush;
  assign id_ex_bubble = stb.id_ex_bubble;
  assign ex_mem_flush = stb.ex_mem_flush;
  assign stall_cycles = stall_q;
  assign miss_timeout = timeout_q;
  assign state        = state_q;

endmodule
